tdm_demux_16ch: RTL and testbench

- Receive-side counterpart of the team's 16:1 channel mux.
- Takes a time-division-multiplexed stream, one channel per valid beat, frame start marked by in_sof.
- Steers each beat into a per-channel shadow register.
- Publishes all channels in parallel as one registered frame with a single-cycle out_valid strobe. Detects framing errors.

---
 rtl/tdm_demux_16ch_if.sv | 22 ++
 rtl/tdm_demux_16ch.sv | 50 +++++
 tb/tb_tdm_demux_16ch.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux_16ch_if.sv
// tdm_demux_16ch_if: TDM stream in, parallel frame out; master drives the stream, slave is the demux
interface tdm_demux_16ch_if #(
    parameter int NUM_CH = 16,
    parameter int DATA_W = 1
);
    localparam int CH_W = $clog2(NUM_CH);
    logic                     in_valid;
    logic                     in_sof;
    logic [DATA_W-1:0]        in_data;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic                     out_valid;
    logic [CH_W-1:0]          ch_idx;
    logic                     sync_err;
    modport master (
        output in_valid, in_sof, in_data,
        input  out_data, out_valid, ch_idx, sync_err
    );
    modport slave (
        input  in_valid, in_sof, in_data,
        output out_data, out_valid, ch_idx, sync_err
    );
endinterface

// File: rtl/tdm_demux_16ch.sv
// tdm_demux_16ch: demux a one-channel-per-beat TDM stream into a registered parallel frame
module tdm_demux_16ch #(
    parameter int NUM_CH = 16,
    parameter int DATA_W = 1
) (
    input logic clk,
    input logic rst,
    tdm_demux_16ch_if.slave bus
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;
    logic [0:0] state;
    // The last channel bypasses the shadow straight into out_data, so no storage for it
    logic [(NUM_CH-1)*DATA_W-1:0] shadow;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            shadow        <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.ch_idx    <= '0;
            bus.sync_err  <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.sync_err  <= 1'b0;
            if (bus.in_valid) begin
                if (bus.in_sof) begin
                    // In RECV ch_idx is never 0, so any sof there aborts a partial frame
                    shadow[DATA_W-1:0] <= bus.in_data;
                    bus.ch_idx         <= CH_W'(1);
                    bus.sync_err       <= state == RECV;
                    state              <= RECV;
                end else if (state == IDLE) begin
                    bus.sync_err <= 1'b1;
                end else if (bus.ch_idx == LAST) begin
                    bus.out_data  <= {bus.in_data, shadow};
                    bus.out_valid <= 1'b1;
                    bus.ch_idx    <= '0;
                    state         <= IDLE;
                end else begin
                    for (int k = 1; k < NUM_CH - 1; k++)
                        if (bus.ch_idx == CH_W'(k)) shadow[k*DATA_W +: DATA_W] <= bus.in_data;
                    bus.ch_idx <= bus.ch_idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tdm_demux_16ch.sv
// tb_tdm_demux_16ch: randomized and directed checks of tdm_demux_16ch against a frame-level model
module tb_tdm_demux_16ch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vec = 0;
    int bad = 0;
    always #5 clk = ~clk;

    tdm_demux_16ch_if #(.NUM_CH(16), .DATA_W(1)) b16();
    tdm_demux_16ch_if #(.NUM_CH(4), .DATA_W(8)) b4();
    tdm_demux_16ch #(.NUM_CH(16), .DATA_W(1)) d16 (.clk(clk), .rst(rst), .bus(b16));
    tdm_demux_16ch #(.NUM_CH(4), .DATA_W(8)) d4 (.clk(clk), .rst(rst), .bus(b4));

    task automatic cmp(input string n, input logic [63:0] a, input logic [63:0] e);
        vec++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // Frame-level model: m_cnt is how many beats of the current frame have been collected
    int          m_cnt = 0;
    logic [15:0] m_acc = '0;
    logic [15:0] m_data = '0;
    logic        m_valid = 1'b0;
    logic        m_err = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_acc = '0; m_data = '0; m_valid = 1'b0; m_err = 1'b0;
        end else begin
            m_valid = 1'b0;
            m_err = 1'b0;
            if (b16.in_valid) begin
                if (b16.in_sof) begin
                    m_err = m_cnt != 0;
                    m_cnt = 1;
                    m_acc[0] = b16.in_data;
                end else if (m_cnt == 0) begin
                    m_err = 1'b1;
                end else begin
                    m_acc[m_cnt] = b16.in_data;
                    m_cnt++;
                    if (m_cnt == 16) begin
                        m_data = m_acc;
                        m_valid = 1'b1;
                        m_cnt = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            cmp("model_out_valid", 64'(b16.out_valid), 64'(m_valid));
            cmp("model_sync_err", 64'(b16.sync_err), 64'(m_err));
            cmp("model_out_data", 64'(b16.out_data), 64'(m_data));
            cmp("model_ch_idx", 64'(b16.ch_idx), 64'(m_cnt));
        end
    end

    task automatic beat16(input logic v, input logic s, input logic d);
        b16.in_valid = v;
        b16.in_sof = s;
        b16.in_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle16();
        beat16(1'b0, 1'($urandom), 1'($urandom));
    endtask

    task automatic frame16(input logic [15:0] f, input int gap_pct);
        for (int i = 0; i < 16; i++) begin
            beat16(1'b1, i == 0, f[i]);
            if (i != 15 && $urandom_range(99) < gap_pct) repeat ($urandom_range(1, 3)) idle16();
        end
    endtask

    task automatic beat4(input logic v, input logic s, input logic [7:0] d);
        b4.in_valid = v;
        b4.in_sof = s;
        b4.in_data = d;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] f;
    logic [31:0] ch4;
    logic [7:0]  idx4;

    initial begin
        b16.in_valid = 1'b0; b16.in_sof = 1'b0; b16.in_data = 1'b0;
        b4.in_valid = 1'b0; b4.in_sof = 1'b0; b4.in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_out_data", 64'(b16.out_data), 64'h0);
        cmp("rst_ch_idx", 64'(b16.ch_idx), 64'h0);
        cmp("rst_out_valid", 64'(b16.out_valid), 64'h0);
        cmp("rst_sync_err", 64'(b16.sync_err), 64'h0);
        cmp("rst4_out_data", 64'(b4.out_data), 64'h0);
        rst = 1'b0;
        idle16();

        frame16(16'hA5C3, 0);
        cmp("clean_valid", 64'(b16.out_valid), 64'h1);
        cmp("clean_data", 64'(b16.out_data), 64'hA5C3);
        cmp("clean_idx", 64'(b16.ch_idx), 64'h0);
        idle16();
        cmp("clean_pulse_end", 64'(b16.out_valid), 64'h0);

        f = 16'hA5C3;
        for (int i = 0; i < 16; i++) begin
            beat16(1'b1, i == 0, f[i]);
            if (i == 4 || i == 11) begin
                repeat (3) begin
                    idle16();
                    cmp("gap_idx", 64'(b16.ch_idx), 64'(i + 1));
                    cmp("gap_no_valid", 64'(b16.out_valid), 64'h0);
                end
            end
        end
        cmp("gap_valid", 64'(b16.out_valid), 64'h1);
        cmp("gap_data", 64'(b16.out_data), 64'hA5C3);

        frame16(16'h1234, 0);
        cmp("b2b_data1", 64'(b16.out_data), 64'h1234);
        cmp("b2b_valid1", 64'(b16.out_valid), 64'h1);
        frame16(16'hFFFF, 0);
        cmp("b2b_data2", 64'(b16.out_data), 64'hFFFF);
        cmp("b2b_valid2", 64'(b16.out_valid), 64'h1);

        repeat (3) begin
            beat16(1'b1, 1'b0, 1'($urandom));
            cmp("idle_err", 64'(b16.sync_err), 64'h1);
            cmp("idle_hold", 64'(b16.out_data), 64'hFFFF);
        end

        f = 16'h5A5A;
        for (int i = 0; i < 9; i++) beat16(1'b1, i == 0, f[i]);
        cmp("abort_idx", 64'(b16.ch_idx), 64'h9);
        f = 16'h00F0;
        beat16(1'b1, 1'b1, f[0]);
        cmp("abort_err", 64'(b16.sync_err), 64'h1);
        cmp("abort_idx1", 64'(b16.ch_idx), 64'h1);
        for (int i = 1; i < 16; i++) begin
            beat16(1'b1, 1'b0, f[i]);
            if (i < 15) cmp("abort_no_valid", 64'(b16.out_valid), 64'h0);
        end
        cmp("abort_valid", 64'(b16.out_valid), 64'h1);
        cmp("abort_data", 64'(b16.out_data), 64'h00F0);

        f = 16'h3C3C;
        for (int i = 0; i < 7; i++) beat16(1'b1, i == 0, f[i]);
        cmp("pre_rst_idx", 64'(b16.ch_idx), 64'h7);
        b16.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        cmp("async_data", 64'(b16.out_data), 64'h0);
        cmp("async_idx", 64'(b16.ch_idx), 64'h0);
        cmp("async_valid", 64'(b16.out_valid), 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle16();
        frame16(16'h8001, 0);
        cmp("post_rst_data", 64'(b16.out_data), 64'h8001);
        cmp("post_rst_valid", 64'(b16.out_valid), 64'h1);

        repeat (25) begin
            frame16(16'($urandom), 30);
            repeat ($urandom_range(0, 8))
                beat16(1'($urandom_range(99) < 70), 1'($urandom_range(9) == 0), 1'($urandom));
        end
        repeat (300) beat16(1'($urandom_range(99) < 80), 1'($urandom_range(11) == 0), 1'($urandom));
        b16.in_valid = 1'b0;

        ch4 = 32'h44332211;
        idx4 = 8'h1;
        for (int i = 0; i < 4; i++) begin
            beat4(1'b1, i == 0, ch4[i*8 +: 8]);
            cmp("ch4_idx", 64'(b4.ch_idx), 64'(idx4[1:0]));
            idx4 = idx4 + 8'h1;
            if (i < 3) cmp("ch4_no_valid", 64'(b4.out_valid), 64'h0);
        end
        cmp("ch4_valid", 64'(b4.out_valid), 64'h1);
        cmp("ch4_data", 64'(b4.out_data), 64'h44332211);
        cmp("ch4_err", 64'(b4.sync_err), 64'h0);
        beat4(1'b0, 1'b0, 8'h0);
        cmp("ch4_pulse_end", 64'(b4.out_valid), 64'h0);
        cmp("ch4_hold", 64'(b4.out_data), 64'h44332211);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
